// File: rtl/mul_exponent_add.sv
// FP32 multiplier exponent stage: biased exponent sum, operand classification and sign.
// Define FPU_MUL_DENORM_EN to honour subnormal operands; otherwise they flush to zero.
module mul_exponent_add #(
  parameter int SPEC_DLY = 7
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic        in_valid,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [9:0]  Ez_add,
  output logic        hid_a,
  output logic        hid_b,
  output logic        out_valid,
  output logic        sign_z,
  output logic        spec_nan,
  output logic        spec_inf,
  output logic        spec_zero,
  output logic        spec_valid
);

  typedef struct packed {
    logic valid;
    logic sign;
    logic nan;
    logic inf;
    logic zero;
  } spec_t;

  logic [7:0]  exp_a, exp_b, eff_a, eff_b;
  logic [22:0] man_a, man_b;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  spec_t       spec_in;

  logic [7:0]  ea_q, eb_q;
  logic        valid_q;
  spec_t       spec_pipe [SPEC_DLY];

  assign exp_a = A[30:23];
  assign exp_b = B[30:23];
  assign man_a = A[22:0];
  assign man_b = B[22:0];

  always_comb begin
    a_nan = (exp_a == 8'hFF) && (man_a != 23'd0);
    b_nan = (exp_b == 8'hFF) && (man_b != 23'd0);
    a_inf = (exp_a == 8'hFF) && (man_a == 23'd0);
    b_inf = (exp_b == 8'hFF) && (man_b == 23'd0);
`ifdef FPU_MUL_DENORM_EN
    a_zero = (exp_a == 8'd0) && (man_a == 23'd0);
    b_zero = (exp_b == 8'd0) && (man_b == 23'd0);
    // A subnormal behaves as exponent 1 with a cleared hidden bit.
    eff_a  = ((exp_a == 8'd0) && (man_a != 23'd0)) ? 8'd1 : exp_a;
    eff_b  = ((exp_b == 8'd0) && (man_b != 23'd0)) ? 8'd1 : exp_b;
`else
    a_zero = (exp_a == 8'd0);
    b_zero = (exp_b == 8'd0);
    eff_a  = exp_a;
    eff_b  = exp_b;
`endif
    spec_in.valid = in_valid;
    spec_in.sign  = A[31] ^ B[31];
    spec_in.nan   = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
    spec_in.inf   = ~spec_in.nan & (a_inf | b_inf);
    spec_in.zero  = ~spec_in.nan & ~(a_inf | b_inf) & (a_zero | b_zero);
  end

  // Stage 1 plus the special-case delay line; spec_pipe[0] is the stage-1 copy.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ea_q    <= 8'd0;
      eb_q    <= 8'd0;
      valid_q <= 1'b0;
      // NOTE: the delay line is a flop shift register, not RAM, so every entry is reset
      // to guarantee no stale valid bit survives a mid-stream reset.
      for (int i = 0; i < SPEC_DLY; i++) spec_pipe[i] <= '0;
    end else if (EN) begin
      ea_q         <= eff_a;
      eb_q         <= eff_b;
      valid_q      <= in_valid;
      spec_pipe[0] <= spec_in;
      for (int i = 1; i < SPEC_DLY; i++) spec_pipe[i] <= spec_pipe[i-1];
    end
  end

  // Stage 2: 10'h381 is -127 in 10-bit two's complement.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Ez_add    <= 10'h000;
      out_valid <= 1'b0;
    end else if (EN) begin
      Ez_add    <= {2'b00, ea_q} + {2'b00, eb_q} + 10'h381;
      out_valid <= valid_q;
    end
  end

`ifdef FPU_MUL_DENORM_EN
  logic hid_a_q, hid_b_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hid_a_q <= 1'b1;
      hid_b_q <= 1'b1;
      hid_a   <= 1'b1;
      hid_b   <= 1'b1;
    end else if (EN) begin
      hid_a_q <= (exp_a != 8'd0);
      hid_b_q <= (exp_b != 8'd0);
      hid_a   <= hid_a_q;
      hid_b   <= hid_b_q;
    end
  end
`else
  assign hid_a = 1'b1;
  assign hid_b = 1'b1;
`endif

  assign spec_valid = spec_pipe[SPEC_DLY-1].valid;
  assign sign_z     = spec_pipe[SPEC_DLY-1].sign;
  assign spec_nan   = spec_pipe[SPEC_DLY-1].nan;
  assign spec_inf   = spec_pipe[SPEC_DLY-1].inf;
  assign spec_zero  = spec_pipe[SPEC_DLY-1].zero;

endmodule

// File: tb/tb_mul_exponent_add.sv
// Directed self-checking bench for mul_exponent_add (default SPEC_DLY of 7).
module tb_mul_exponent_add;

  localparam int SPEC_DLY = 7;

  logic        CLK, RST, EN, in_valid;
  logic [31:0] A, B;
  logic [9:0]  Ez_add;
  logic        hid_a, hid_b, out_valid, sign_z;
  logic        spec_nan, spec_inf, spec_zero, spec_valid;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [31:0] a, b;
    logic [9:0]  ez;
    logic        ha, hb, sign, nan, inf, zero;
  } vec_t;

  mul_exponent_add #(.SPEC_DLY(SPEC_DLY)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .in_valid(in_valid), .A(A), .B(B),
    .Ez_add(Ez_add), .hid_a(hid_a), .hid_b(hid_b), .out_valid(out_valid),
    .sign_z(sign_z), .spec_nan(spec_nan), .spec_inf(spec_inf),
    .spec_zero(spec_zero), .spec_valid(spec_valid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic flush();
    EN = 1'b1;
    in_valid = 1'b0;
    repeat (SPEC_DLY + 2) step();
  endtask

  task automatic test_reset();
    RST = 1'b1; EN = 1'b1; in_valid = 1'b0; A = '0; B = '0;
    step(); step();
    checks++;
    if (Ez_add !== 10'h000 || hid_a !== 1'b1 || hid_b !== 1'b1 || out_valid !== 1'b0 ||
        sign_z !== 1'b0 || spec_nan !== 1'b0 || spec_inf !== 1'b0 || spec_zero !== 1'b0 ||
        spec_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: got ez=%h ha=%b hb=%b ov=%b s=%b nan=%b inf=%b zero=%b sv=%b, want ez=000 ha=1 hb=1 rest 0",
               Ez_add, hid_a, hid_b, out_valid, sign_z, spec_nan, spec_inf, spec_zero, spec_valid);
    end
    RST = 1'b0;
  endtask

  task automatic test_directed_vectors();
    vec_t v [9];
    v[0] = '{"basic_1x2",   32'h3F800000, 32'h40000000, 10'h080, 1, 1, 0, 0, 0, 0};
    v[1] = '{"max_normal",  32'h7F7FFFFF, 32'h7F7FFFFF, 10'h17D, 1, 1, 0, 0, 0, 0};
    v[2] = '{"min_normal",  32'h00800000, 32'h00800000, 10'h383, 1, 1, 0, 0, 0, 0};
`ifdef FPU_MUL_DENORM_EN
    v[3] = '{"subnormal",   32'h00000001, 32'h00000001, 10'h383, 0, 0, 0, 0, 0, 0};
`else
    v[3] = '{"subnormal",   32'h00000001, 32'h00000001, 10'h381, 1, 1, 0, 0, 0, 1};
`endif
    v[4] = '{"inf_x_zero",  32'h7F800000, 32'h00000000, 10'h080, 1, 1, 0, 1, 0, 0};
    v[5] = '{"neginf_x_2",  32'hFF800000, 32'h40000000, 10'h100, 1, 1, 1, 0, 1, 0};
    v[6] = '{"nan_x_inf",   32'h7FC00000, 32'h7F800000, 10'h17F, 1, 1, 0, 1, 0, 0};
    v[7] = '{"negzero_x_2", 32'h80000000, 32'h40000000, 10'h001, 1, 1, 1, 0, 0, 1};
`ifdef FPU_MUL_DENORM_EN
    v[8] = '{"zero_x_nan",  32'h00000000, 32'h7F800001, 10'h080, 0, 1, 0, 1, 0, 0};
`else
    v[8] = '{"zero_x_nan",  32'h00000000, 32'h7F800001, 10'h080, 1, 1, 0, 1, 0, 0};
`endif
    flush();
    foreach (v[i]) begin
      A = v[i].a; B = v[i].b; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      checks++;
      if (Ez_add !== v[i].ez || out_valid !== 1'b1 || hid_a !== v[i].ha || hid_b !== v[i].hb) begin
        failures++;
        $display("FAIL %s_stage2: got ez=%h ov=%b ha=%b hb=%b, want ez=%h ov=1 ha=%b hb=%b",
                 v[i].name, Ez_add, out_valid, hid_a, hid_b, v[i].ez, v[i].ha, v[i].hb);
      end
      checks++;
      if (spec_valid !== 1'b0) begin
        failures++;
        $display("FAIL %s_spec_early: got spec_valid=%b, want 0", v[i].name, spec_valid);
      end
      repeat (SPEC_DLY - 2) step();
      checks++;
      if (spec_valid !== 1'b1 || sign_z !== v[i].sign || spec_nan !== v[i].nan ||
          spec_inf !== v[i].inf || spec_zero !== v[i].zero) begin
        failures++;
        $display("FAIL %s_spec: got sv=%b s=%b nan=%b inf=%b zero=%b, want sv=1 s=%b nan=%b inf=%b zero=%b",
                 v[i].name, spec_valid, sign_z, spec_nan, spec_inf, spec_zero,
                 v[i].sign, v[i].nan, v[i].inf, v[i].zero);
      end
    end
  endtask

  task automatic test_back_to_back();
    // Pair i: Ea = 120+i, Eb = 10+3i, B sign = i[0]  ->  Ez = 3+4i, sign_z = i[0].
    logic [9:0] exp_ez [8] = '{10'd3, 10'd7, 10'd11, 10'd15, 10'd19, 10'd23, 10'd27, 10'd31};
    logic       exp_sg [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int idx = 0, got_o = 0, got_s = 0;
    logic [9:0] p_ez;
    logic p_ov, p_sv, p_sg;
    logic stall;
    flush();
    for (int c = 0; c < 40; c++) begin
      stall = (c >= 3 && c < 6);
      EN = !stall;
      if (stall) begin
        in_valid = 1'b1; A = 32'h7FC00000; B = 32'h7FC00000;
      end else if (idx < 8) begin
        in_valid = 1'b1;
        A = {1'b0, 8'(120 + idx), 23'h001234};
        B = {idx[0], 8'(10 + 3 * idx), 23'h0};
        idx++;
      end else begin
        in_valid = 1'b0;
      end
      p_ez = Ez_add; p_ov = out_valid; p_sv = spec_valid; p_sg = sign_z;
      step();
      if (stall) begin
        checks++;
        if (Ez_add !== p_ez || out_valid !== p_ov || spec_valid !== p_sv || sign_z !== p_sg) begin
          failures++;
          $display("FAIL stall_freeze_c%0d: got ez=%h ov=%b sv=%b s=%b, want ez=%h ov=%b sv=%b s=%b",
                   c, Ez_add, out_valid, spec_valid, sign_z, p_ez, p_ov, p_sv, p_sg);
        end
      end else begin
        if (out_valid) begin
          if (got_o < 8) begin
            checks++;
            if (Ez_add !== exp_ez[got_o]) begin
              failures++;
              $display("FAIL stream_ez%0d: got %h, want %h", got_o, Ez_add, exp_ez[got_o]);
            end
          end
          got_o++;
        end
        if (spec_valid) begin
          if (got_s < 8) begin
            checks++;
            if (sign_z !== exp_sg[got_s] || spec_nan !== 1'b0 || spec_inf !== 1'b0 || spec_zero !== 1'b0) begin
              failures++;
              $display("FAIL stream_spec%0d: got s=%b nan=%b inf=%b zero=%b, want s=%b and no special",
                       got_s, sign_z, spec_nan, spec_inf, spec_zero, exp_sg[got_s]);
            end
          end
          got_s++;
        end
      end
    end
    EN = 1'b1;
    checks++;
    if (got_o != 8) begin
      failures++;
      $display("FAIL stream_out_count: got %0d, want 8", got_o);
    end
    checks++;
    if (got_s != 8) begin
      failures++;
      $display("FAIL stream_spec_count: got %0d, want 8", got_s);
    end
  endtask

  task automatic test_reset_mid_op();
    int pulses = 0;
    flush();
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1;
      A = 32'h3F800000; B = 32'h40000000;
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL midrst_inflight: got out_valid=%b, want 1", out_valid);
    end
    #3 RST = 1'b1;
    #1;
    checks++;
    if (Ez_add !== 10'h000 || hid_a !== 1'b1 || hid_b !== 1'b1 || out_valid !== 1'b0 ||
        sign_z !== 1'b0 || spec_nan !== 1'b0 || spec_inf !== 1'b0 || spec_zero !== 1'b0 ||
        spec_valid !== 1'b0) begin
      failures++;
      $display("FAIL midrst_async: got ez=%h ha=%b hb=%b ov=%b s=%b nan=%b inf=%b zero=%b sv=%b, want ez=000 ha=1 hb=1 rest 0",
               Ez_add, hid_a, hid_b, out_valid, sign_z, spec_nan, spec_inf, spec_zero, spec_valid);
    end
    step(); step();
    #2 RST = 1'b0;
    for (int c = 0; c < SPEC_DLY + 4; c++) begin
      step();
      if (out_valid !== 1'b0 || spec_valid !== 1'b0) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL midrst_no_pulse: got %0d cycles with a valid pulse, want 0", pulses);
    end
    A = 32'h40000000; B = 32'h40000000; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b1 || Ez_add !== 10'h081) begin
      failures++;
      $display("FAIL midrst_resume: got ov=%b ez=%h, want ov=1 ez=081", out_valid, Ez_add);
    end
  endtask

  function automatic logic bubble_pat(int c);
    return (c >= 0) && (c < 8) && (c % 2 == 0);
  endfunction

  task automatic test_bubbles();
    logic ov [20];
    logic sv [20];
    logic e_ov, e_sv;
    flush();
    for (int c = 0; c < 20; c++) begin
      in_valid = bubble_pat(c);
      A = 32'h3F800000; B = 32'h3F800000;
      step();
      ov[c] = out_valid;
      sv[c] = spec_valid;
    end
    for (int j = 0; j < 20; j++) begin
      e_ov = bubble_pat(j - 1);
      e_sv = bubble_pat(j - SPEC_DLY + 1);
      checks++;
      if (ov[j] !== e_ov || sv[j] !== e_sv) begin
        failures++;
        $display("FAIL bubble_edge%0d: got ov=%b sv=%b, want ov=%b sv=%b", j, ov[j], sv[j], e_ov, e_sv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed_vectors();
    test_back_to_back();
    test_reset_mid_op();
    test_bubbles();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_exponent_add.md
# mul_exponent_add

Upstream pipelined exponent stage of the FP32 multiplier datapath. Each cycle it accepts two IEEE-754 single-precision operands and computes the biased product exponent `Ez_add = Ea + Eb − 127` as a 10-bit two's-complement value, which feeds the exponent-update stage. It also classifies the operands (zero/inf/NaN), produces the product sign, and carries these flags down a delay line so they arrive aligned with the final packed result.

## Interface
- `SPEC_DLY`, 7, cycles from input capture to `spec_*` outputs; legal range 2..15.
- `CLK` input 1: clock, rising edge.
- `RST` input 1: asynchronous, active-high reset.
- `EN` input 1: pipeline advance enable. When low, all registers hold.
- `in_valid` input 1: `A`/`B` hold a valid operand pair.
- `A` input 32: operand A, IEEE-754 single.
- `B` input 32: operand B, IEEE-754 single.
- `Ez_add` output 10: `Ea + Eb − 127`, two's complement.
- `hid_a` output 1: hidden bit of A (1 for normal, 0 for subnormal/zero). Driven only in DENORM mode; constant 1 otherwise.
- `hid_b` output 1: hidden bit of B, same rules as `hid_a`.
- `out_valid` output 1: `Ez_add`/`hid_*` valid (latency 2).
- `sign_z` output 1: `A[31] ^ B[31]`, delayed `SPEC_DLY`.
- `spec_nan` output 1: result is NaN, delayed `SPEC_DLY`.
- `spec_inf` output 1: result is ±inf, delayed `SPEC_DLY`.
- `spec_zero` output 1: result is ±0, delayed `SPEC_DLY`.
- `spec_valid` output 1: `sign_z`/`spec_*` valid, delayed `SPEC_DLY`.

## Operation
- **Stage 1 (register)**
  - Capture `Ea=A[30:23]`, `Eb=B[30:23]`, sign XOR, and the classification bits.
  - The stage also registers `in_valid`.
- **Classification** (zero/subnormal rules per Configuration):
  - NaN: `E==255` with nonzero mantissa.
  - Inf: `E==255` with zero mantissa.
- **Special outcome priority**
  1. `spec_nan=1` if either operand is NaN, or if one operand is inf and the other is zero.
  2. Else `spec_inf=1` if either operand is inf.
  3. Else `spec_zero=1` if either operand is zero.
  4. At most one `spec_*` bit is high in any cycle.
- **Stage 2 (register)**
  - `Ez_add = {2'b0,Ea'} + {2'b0,Eb'} + 10'h381`, where `10'h381` is −127 and `Ea'`/`Eb'` are the effective exponents.
  - Arithmetic is modulo 2^10 with no saturation.
  - Result range is −127..+381. Bit 9 is the sign, which downstream uses for underflow detection.
  - `Ez_add` is computed even for special operands (e.g. 255+255−127 = 383 = `10'h17F`). Downstream ignores it when a `spec_*` bit is set.
- **Delay line**
  - `{spec_valid, sign_z, spec_nan, spec_inf, spec_zero}` passes through a shift register.
  - Its total depth, including stage 1, is `SPEC_DLY`.
  - It advances only when `EN=1`.
- **Bubbles**
  - When `in_valid=0` and `EN=1`, a bubble propagates: `valid=0`.
  - Datapath registers still load, so their contents are don't-care.

## Timing
- **Latencies**
  - Capture edge k with `EN=1`.
  - `Ez_add`/`hid_*`/`out_valid` are valid after edge k+1 (latency 2 edges, counting capture).
  - `spec_*`/`sign_z`/`spec_valid` appear after `SPEC_DLY` advancing edges.
  - Throughput is one operand pair per cycle while `EN=1`.
- **`EN=0`**
  - Every register, including the valid bits, holds its value.
  - Outputs stay stable.
  - Inputs presented during `EN=0` are dropped.
- **Reset**
  - `RST=1` clears every register immediately, without waiting for a clock edge.
  - Reset values: `Ez_add=10'h000`, `hid_a=hid_b=1`, `out_valid=0`, `sign_z=0`, all `spec_*=0`, `spec_valid=0`.
  - Reset asserted mid-stream discards all in-flight operands; nothing is emitted after deassert until new `in_valid` pairs propagate.
  - First capture is on the first rising edge with `RST=0`.

## Configuration
- **`FPU_MUL_DENORM_EN` defined**
  - A subnormal operand (`E==0`, mantissa≠0) uses effective exponent 1 and `hid=0`.
  - Zero is `E==0` and mantissa==0.
- **Undefined (flush-to-zero)**
  - `E==0` with any mantissa is classified as zero.
  - Effective exponent equals the raw exponent.
  - `hid_a=hid_b=1` constantly.

## Test plan
- **Basic product:** A=`0x3F800000` (1.0), B=`0x40000000` (2.0), `in_valid=1` → 2 cycles later `Ez_add=10'h080`, `out_valid=1`; `SPEC_DLY` cycles later `sign_z=0`, all `spec_*=0`, `spec_valid=1`.
- **Exponent range extremes:**
  - A=B=`0x7F7FFFFF` → `Ez_add=10'h17D` (381).
  - A=B=`0x00800000` → `Ez_add=10'h383` (−125).
  - A=B=`0x00000001`: with `FPU_MUL_DENORM_EN` → `Ez_add=10'h383`, `hid_a=hid_b=0`; without it → `spec_zero=1`.
- **Special-case priority:**
  - inf×0 (`0x7F800000`,`0x00000000`) → `spec_nan=1` only.
  - −inf×2.0 (`0xFF800000`,`0x40000000`) → `spec_inf=1`, `sign_z=1`.
  - NaN×inf (`0x7FC00000`,`0x7F800000`) → `spec_nan=1`.
- **Back-to-back stream with `EN` stall:**
  - Send 8 consecutive pairs, with `EN=0` for 3 cycles mid-stream.
  - Required: outputs freeze during the stall, all 8 results emerge in order with correct values, and no duplicate or lost `out_valid`.
- **Reset mid-operation:**
  - Assert `RST` asynchronously, between clock edges, with 4 pairs in flight.
  - Required: all outputs go to their reset values immediately, and no `out_valid`/`spec_valid` pulses appear after deassert until new inputs arrive.
- **Bubble handling:** alternate `in_valid` 1/0 → `out_valid` and `spec_valid` reproduce the 1/0 pattern at latency 2 and `SPEC_DLY` respectively.
